// File: rtl/onehot_pkg.sv
// Shared constants and helpers for the one-hot round-robin arbiter.
package onehot_pkg;

    localparam int unsigned N_REQ_DEFAULT  = 8;
    localparam int unsigned CODE_W_DEFAULT = 3;

    // Binary index of the set bit; OR-encoding is exact for one-hot/zero input.
    function automatic logic [CODE_W_DEFAULT-1:0] onehot_to_index(
        input logic [N_REQ_DEFAULT-1:0] oh
    );
        logic [CODE_W_DEFAULT-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ_DEFAULT; i++) begin
            if (oh[i]) begin
                idx = idx | CODE_W_DEFAULT'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational wrap-around priority search starting at ptr.
module rr_pick
    import onehot_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEFAULT,
    parameter int unsigned CODE_W = CODE_W_DEFAULT
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [CODE_W-1:0] ptr,
    output logic [N_REQ-1:0]  pick,
    output logic [CODE_W-1:0] pick_idx,
    output logic              any
);

    // First set request at ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        int unsigned j;
        logic [CODE_W-1:0] jj;
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        j        = 0;
        jj       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j  = (32'(ptr) + i) % N_REQ;
            jj = CODE_W'(j);
            if (!any && req[jj]) begin
                any      = 1'b1;
                pick[jj] = 1'b1;
                pick_idx = jj;
            end
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// One-hot round-robin arbiter with valid/ready grant handshake.
// Optional macro RR_ARB_CODE_EN adds the registered binary grant index gnt_code.
module onehot_rr_arbiter
    import onehot_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEFAULT,
    parameter int unsigned CODE_W = CODE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic              gnt_valid,
    input  logic              gnt_ready,
`ifdef RR_ARB_CODE_EN
    output logic [CODE_W-1:0] gnt_code,
`endif
    output logic              busy
);

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [CODE_W-1:0] gnt_idx;
    logic [CODE_W-1:0] ptr_adv;
    logic [CODE_W-1:0] search_ptr;
    logic [N_REQ-1:0]  pick;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;
    logic              handshake;
    logic              slot_free;

`ifdef RR_ARB_CODE_EN
    logic [CODE_W-1:0] gnt_code_q, gnt_code_d;
    assign gnt_idx  = gnt_code_q;
    assign gnt_code = gnt_code_q;
`else
    logic unused_pick_idx;
    assign gnt_idx         = CODE_W'(onehot_to_index(N_REQ_DEFAULT'(gnt_q)));
    assign unused_pick_idx = ^pick_idx;
`endif

    assign handshake  = gnt_valid_q && gnt_ready;
    assign slot_free  = !gnt_valid_q || gnt_ready;
    assign ptr_adv    = (32'(gnt_idx) + 32'd1 >= N_REQ) ? '0 : gnt_idx + CODE_W'(1);
    // A handshake advances the pointer and the same-edge search uses it.
    assign search_ptr = handshake ? ptr_adv : ptr_q;

    rr_pick #(
        .N_REQ  (N_REQ),
        .CODE_W (CODE_W)
    ) u_pick (
        .req      (req),
        .ptr      (search_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // Next grant: hold while stalled, otherwise load the fresh pick (or empty).
    always_comb begin
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_CODE_EN
        gnt_code_d  = gnt_code_q;
`endif
        if (handshake) begin
            ptr_d = ptr_adv;
        end
        if (slot_free) begin
            gnt_d       = pick;
            gnt_valid_d = pick_any;
`ifdef RR_ARB_CODE_EN
            gnt_code_d  = pick_idx;
`endif
        end
    end

    // Grant and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef RR_ARB_CODE_EN
            gnt_code_q  <= '0;
`endif
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_CODE_EN
            gnt_code_q  <= gnt_code_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign busy      = (|req) | gnt_valid_q;

endmodule
